// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants and GF(2^8) helper
// Holds the key-schedule FSM state type, the round count, the round-constant
// table and the 128-bit key / 32-bit word typedefs used by the AES blocks.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINISH
  } state_t;

  typedef logic [127:0] key_t;
  typedef logic [31:0]  word_t;

  localparam logic [7:0] RCON_TABLE [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box
// Ports: a - input byte; y - substituted byte.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0 sits in the top byte, so entry n starts at bit (255-n)*8 = {~n, 3'b0}.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_sched.sv
// rtl/aes_key_sched.sv - AES-128 round-key expander with valid/ready output
// Ports: clk, reset (async, active-high); start/key_in request an expansion;
// rk_valid/rk_ready handshake round keys rk_data tagged with rk_round 0..10;
// busy is high outside IDLE; done pulses once after round key 10 is taken.
module aes_key_sched #(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS  // only 10 is supported
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_data,
  output logic         busy,
  output logic         done
);

  import aes_pkg::*;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t     state;
  logic [7:0] rcon;
  word_t      w0, w1, w2, w3, w4, w5, w6, w7;
  word_t      rot, sub;
  key_t       next_key;

  // Next round key is derived from the registered key so a new key is ready
  // every cycle the consumer keeps rk_ready high.
  assign {w0, w1, w2, w3} = rk_data;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a(rot[8*i +: 8]),
      .y(sub[8*i +: 8])
    );
  end

  assign w4 = w0 ^ sub ^ {rcon, 24'h0};
  assign w5 = w4 ^ w1;
  assign w6 = w5 ^ w2;
  assign w7 = w6 ^ w3;
  assign next_key = {w4, w5, w6, w7};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rk_round <= 4'd0;
      rk_data  <= '0;
      rcon     <= RCON_TABLE[0];
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rk_data  <= key_in;
            rk_round <= 4'd0;
            rcon     <= RCON_TABLE[0];
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (rk_ready) begin
            if (rk_round == LAST_ROUND) begin
              rk_valid <= 1'b0;
              done     <= 1'b1;
              state    <= FINISH;
            end else begin
              rk_data  <= next_key;
              rk_round <= rk_round + 4'd1;
              rcon     <= xtime(rcon);
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// tb/tb_aes_key_sched.sv - directed self-checking bench for aes_key_sched
module tb_aes_key_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_round;
  logic [127:0] rk_data;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [127:0] got_key   [11];
  logic [3:0]   got_round [11];
  int           nk;
  int           done_at;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [127:0] fips_rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_key_sched #(.NUM_ROUNDS(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_in   (key_in),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_round (rk_round),
    .rk_data  (rk_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 128'(rk_valid), 128'd0);
    check_eq({tag, "_busy"},  128'(busy),     128'd0);
    check_eq({tag, "_done"},  128'(done),     128'd0);
    check_eq({tag, "_round"}, 128'(rk_round), 128'd0);
    check_eq({tag, "_data"},  rk_data,        128'd0);
  endtask

  // Called at a negedge while the DUT is IDLE; returns at the negedge of the
  // IDLE cycle that follows FINISH.
  task automatic expand(input logic [127:0] key, input bit rnd, input bit poke, input bit hold_start);
    logic [127:0] hold_d;
    logic [3:0]   hold_r;
    bit           stalled;
    stalled = 1'b0;
    hold_d  = '0;
    hold_r  = '0;
    nk      = 0;
    done_at = -1;
    for (int i = 0; i < 11; i++) begin
      got_key[i]   = '0;
      got_round[i] = '1;
    end
    key_in   = key;
    start    = 1'b1;
    rk_ready = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 0) check_eq("valid_latency", 128'(rk_valid), 128'd1);
      if (!hold_start) start = 1'b0;
      if (poke && k == 3) begin
        start  = 1'b1;
        key_in = ~key;
      end
      if (poke && k == 4) start = 1'b0;
      if (done) begin
        done_at = k + 1;
        check_eq("valid_low_in_finish", 128'(rk_valid), 128'd0);
        break;
      end
      if (stalled) begin
        check_eq("stall_data",  rk_data,          hold_d);
        check_eq("stall_round", 128'(rk_round),   128'(hold_r));
      end
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_valid && rk_ready) begin
        if (nk < 11) begin
          got_key[nk]   = rk_data;
          got_round[nk] = rk_round;
        end
        nk++;
        stalled = 1'b0;
      end else begin
        stalled = rk_valid;
        hold_d  = rk_data;
        hold_r  = rk_round;
      end
    end
    @(negedge clk);
    check_eq("done_one_cycle", 128'(done), 128'd0);
    check_eq("idle_not_busy",  128'(busy), 128'd0);
  endtask

  task automatic verify_fips(input string tag);
    check_eq({tag, "_count"}, 128'(nk), 128'd11);
    for (int i = 0; i < 11; i++) begin
      check_eq($sformatf("%s_rk%0d", tag, i),    got_key[i],          fips_rk[i]);
      check_eq($sformatf("%s_round%0d", tag, i), 128'(got_round[i]),  128'(i));
    end
  endtask

  task automatic verify_zero(input string tag);
    check_eq({tag, "_count"}, 128'(nk),   128'd11);
    check_eq({tag, "_rk0"},   got_key[0], 128'd0);
    check_eq({tag, "_rk1"},   got_key[1], 128'h62636363626363636263636362636363);
    check_eq({tag, "_rk10"},  got_key[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
  endtask

  initial begin
    int seen_done;
    reset    = 1'b1;
    start    = 1'b0;
    rk_ready = 1'b0;
    key_in   = K_FIPS;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    expand(K_FIPS, 1'b0, 1'b0, 1'b0);
    check_eq("t1_done_latency", 128'(done_at), 128'd12);
    verify_fips("t1");

    expand(K_FIPS, 1'b1, 1'b0, 1'b0);
    check_eq("t2_done_seen", 128'(done_at > 0), 128'd1);
    verify_fips("t2");

    expand(128'd0, 1'b0, 1'b0, 1'b0);
    check_eq("t3_done_latency", 128'(done_at), 128'd12);
    verify_zero("t3");

    expand(K_FIPS, 1'b0, 1'b1, 1'b0);
    check_eq("t4_done_latency", 128'(done_at), 128'd12);
    verify_fips("t4");

    // Abort an expansion at round 5 with an asynchronous reset.
    key_in   = K_FIPS;
    start    = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && rk_round != 4'd5; c++) @(negedge clk);
    check_eq("t5_at_round5", 128'(rk_round), 128'd5);
    rk_ready = 1'b0;
    reset    = 1'b1;
    #1;
    check_reset_outputs("t5_async");
    @(negedge clk);
    check_reset_outputs("t5_held");
    reset     = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check_eq("t5_no_done", 128'(seen_done), 128'd0);
    check_eq("t5_idle",    128'(busy),      128'd0);
    expand(K_FIPS, 1'b0, 1'b0, 1'b0);
    check_eq("t5_done_latency", 128'(done_at), 128'd12);
    verify_fips("t5");

    // start held high: each run is accepted in the IDLE cycle after FINISH.
    expand(K_FIPS, 1'b0, 1'b0, 1'b1);
    check_eq("t6a_done_latency", 128'(done_at), 128'd12);
    verify_fips("t6a");
    expand(128'd0, 1'b0, 1'b0, 1'b1);
    check_eq("t6b_done_latency", 128'(done_at), 128'd12);
    verify_zero("t6b");
    expand(K_FIPS, 1'b0, 1'b0, 1'b1);
    check_eq("t6c_done_latency", 128'(done_at), 128'd12);
    verify_fips("t6c");
    start = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
